mul_share_arbiter: RTL and testbench

//   Shares one combinational MUL array (N x N -> 2N, unsigned) between two requesters.
//   - Round-robin arbitration; operands registered in front of the array, product

---
 rtl/mul_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one unsigned N x N multiplier between two requesters.
// Optional MUL_ARB_PIPE_EN adds an EXEC2 stage with a registered product (pipe_q).
module mul_share_arbiter #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_data,
    output logic           busy
);

`ifdef MUL_ARB_PIPE_EN
    typedef enum logic [1:0] {IDLE, EXEC, EXEC2, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic           tag_q, tag_d;
    logic           last_grant_q, last_grant_d;
    logic [2*N-1:0] rsp_data_q, rsp_data_d;
    logic           rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;
`ifdef MUL_ARB_PIPE_EN
    logic [2*N-1:0] pipe_q, pipe_d;
`endif

    logic           grant;
    logic           accept;
    logic [2*N-1:0] a_ext, b_ext, product;

    // Contention alternates away from the last winner; otherwise the lone valid one wins.
    assign grant = (&req_valid) ? ~last_grant_q : req_valid[1];

    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && !rst && req_valid[grant])
            req_ready[grant] = 1'b1;
    end

    assign accept  = |(req_valid & req_ready);
    assign a_ext   = {{N{1'b0}}, op_a_q};
    assign b_ext   = {{N{1'b0}}, op_b_q};
    assign product = a_ext * b_ext;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
`ifdef MUL_ARB_PIPE_EN
        pipe_d       = pipe_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d       = grant ? req1_a : req0_a;
                    op_b_d       = grant ? req1_b : req0_b;
                    tag_d        = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
`ifdef MUL_ARB_PIPE_EN
                pipe_d      = product;
                state_d     = EXEC2;
`else
                rsp_data_d  = product;
                rsp_id_d    = tag_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
`endif
            end
`ifdef MUL_ARB_PIPE_EN
            EXEC2: begin
                rsp_data_d  = pipe_q;
                rsp_id_d    = tag_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            tag_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
`ifdef MUL_ARB_PIPE_EN
            pipe_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            tag_q        <= tag_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef MUL_ARB_PIPE_EN
            pipe_q       <= pipe_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter; adapts latency/spacing when MUL_ARB_PIPE_EN is defined.
module tb_mul_share_arbiter;

    localparam int N = 16;
`ifdef MUL_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk, rst;
    logic [1:0]     req_valid, req_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id, busy;
    logic [2*N-1:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    mul_share_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (req_ready == 2'b00 && k < 20) begin
            step();
            k++;
        end
        chk("ready_wait", {63'd0, req_ready != 2'b00}, 64'd1);
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 20) begin
            step();
            k++;
        end
        chk("rsp_wait", {63'd0, rsp_valid}, 64'd1);
    endtask

    // One solo op from requester r; operands are scrambled right after acceptance.
    task automatic do_op(input logic r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input string tag);
        if (r) begin req1_a = a; req1_b = b; end
        else   begin req0_a = a; req0_b = b; end
        req_valid = r ? 2'b10 : 2'b01;
        #1;
        wait_ready();
        chk({tag, "_ready"}, {62'd0, req_ready}, r ? 64'd2 : 64'd1);
        step();
        req_valid = 2'b00;
        req0_a = 16'h1234; req0_b = 16'h5678; req1_a = 16'h9ABC; req1_b = 16'hDEF0;
        wait_rsp();
        chk({tag, "_data"}, {32'd0, rsp_data}, {32'd0, exp});
        chk({tag, "_id"}, {63'd0, rsp_id}, {63'd0, r});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int acc_prev;
        logic [1:0] exp_rdy;
        rst = 1'b1; req_valid = 2'b01; rsp_ready = 1'b1;
        req0_a = 16'd3; req0_b = 16'd5; req1_a = '0; req1_b = '0;
        step();
        step();
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_id", {63'd0, rsp_id}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        step();

        // Test 1: single requester, exact latency
        req_valid = 2'b01; req0_a = 16'd3; req0_b = 16'd5;
        #1;
        chk("t1_ready", {62'd0, req_ready}, 64'd1);
        step();
        req_valid = 2'b00;
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_exec_valid", {63'd0, rsp_valid}, 64'd0);
        for (int i = 0; i < LAT - 1; i++) begin
            step();
            chk("t1_exec2_valid", {63'd0, rsp_valid}, 64'd0);
        end
        step();
        chk("t1_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t1_data", {32'd0, rsp_data}, 64'd15);
        chk("t1_id", {63'd0, rsp_id}, 64'd0);
        step();
        chk("t1_done_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t1_done_busy", {63'd0, busy}, 64'd0);
        chk("t1_hold_data", {32'd0, rsp_data}, 64'd15);

        // Test 2: continuous contention after reset -> 0,1,0,1
        do_reset();
        req0_a = 16'd2; req0_b = 16'd3; req1_a = 16'd7; req1_b = 16'd11;
        req_valid = 2'b11;
        acc_prev = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            wait_ready();
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("t2_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
            if (k > 0) chk("t2_spacing", 64'(cyc - acc_prev), 64'(LAT + 2));
            acc_prev = cyc;
            step();
            wait_rsp();
            chk("t2_id", {63'd0, rsp_id}, {63'd0, exp_rdy[1]});
            chk("t2_data", {32'd0, rsp_data}, exp_rdy[1] ? 64'd77 : 64'd6);
        end
        req_valid = 2'b00;
        step();

        // Test 3: width corners on requester 1
        do_op(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "t3_max");
        step();
        do_op(1'b1, 16'h0000, 16'hFFFF, 32'h0, "t3_zero");
        step();

        // Test 4: backpressure while both requesters wait
        rsp_ready = 1'b0;
        do_op(1'b0, 16'd100, 16'd200, 32'd20000, "t4");
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("t4_hold_data", {32'd0, rsp_data}, 64'd20000);
            chk("t4_hold_id", {63'd0, rsp_id}, 64'd0);
            chk("t4_hold_ready", {62'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 2'b00;
        #1;
        chk("t4_release_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t4_release_busy", {63'd0, busy}, 64'd0);
        step();

        // Test 5: reset while in EXEC
        req_valid = 2'b10; req1_a = 16'd9; req1_b = 16'd9;
        #1;
        chk("t5_ready", {62'd0, req_ready}, 64'd2);
        step();
        req_valid = 2'b00;
        chk("t5_exec_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        chk("t5_busy", {63'd0, busy}, 64'd0);
        req_valid = 2'b11;
        #1;
        chk("t5_next_grant", {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
